// File: rtl/ext_imm_unit_pkg.sv
// Shared encodings, FSM state type and latency helper for the immediate extender.
package ext_imm_pkg;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;
  localparam logic [1:0] IMM_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of ROT cycles needed to rotate by 2*rot with the given step size.
  function automatic int rot_cycles(input logic [3:0] rot, input int step);
    return (2 * int'(rot) + step - 1) / step;
  endfunction

endpackage

// File: rtl/ext_imm_unit_if.sv
// Request/response handshake bundle between decode, the extender and the ALU B mux.
interface ext_imm_unit_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        imm_src;
  logic [IMM_W-1:0]  imm;
  logic              carry_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ext_imm;
  logic              carry_out;
  logic              mode_err;

  modport master (
    output in_valid, imm_src, imm, carry_in, out_ready,
    input  in_ready, out_valid, ext_imm, carry_out, mode_err
  );

  modport slave (
    input  in_valid, imm_src, imm, carry_in, out_ready,
    output in_ready, out_valid, ext_imm, carry_out, mode_err
  );
endinterface

// File: rtl/ext_imm_unit_ror_step.sv
// Combinational rotate-right of a DATA_W word by 0..ROT_STEP bits.
module ror_step #(
  parameter int DATA_W   = 32,
  parameter int ROT_STEP = 2,
  parameter int AW       = $clog2(ROT_STEP + 1)
) (
  input  logic [DATA_W-1:0] din,
  input  logic [AW-1:0]     amt,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] cand [ROT_STEP+1];

  assign cand[0] = din;

  for (genvar i = 1; i <= ROT_STEP; i++) begin : g_rot
    assign cand[i] = {din[i-1:0], din[DATA_W-1:i]};
  end

  // Select the candidate rotation; amounts above ROT_STEP never occur but fall back to no rotation.
  always_comb begin
    dout = din;
    if (int'(amt) <= ROT_STEP) dout = cand[amt];
  end

endmodule

// File: rtl/ext_imm_unit.sv
// Handshaked immediate extender: MEM/BR/reserved modes finish in one cycle,
// DP rotated immediates are rotated ROT_STEP bits per cycle in the ROT state.
//
// state | meaning
// IDLE  | ready for a request
// ROT   | rotating the DP imm8, rem bits still to go
// DONE  | result presented, waiting for out_ready
module ext_imm_unit
  import ext_imm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 24,
  parameter int ROT_STEP = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  output logic         busy,
  ext_imm_unit_if.slave bus
);

  localparam int AW = $clog2(ROT_STEP + 1);

  state_t            state;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] rot_out;
  logic [4:0]        rem;
  logic [AW-1:0]     step;
  logic              carry_r;
  logic              err_r;

  assign step = (rem >= 5'(ROT_STEP)) ? AW'(ROT_STEP) : rem[AW-1:0];

  ror_step #(.DATA_W(DATA_W), .ROT_STEP(ROT_STEP), .AW(AW)) u_ror (
    .din  (res),
    .amt  (step),
    .dout (rot_out)
  );

  assign bus.in_ready  = (state == IDLE) && !flush;
  assign bus.out_valid = (state == DONE);
  assign bus.ext_imm   = res;
  assign bus.carry_out = carry_r;
  assign bus.mode_err  = err_r;
  assign busy          = (state != IDLE);

  // Main FSM: accept, iterative rotate, hold result until consumed; flush aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      res     <= '0;
      rem     <= '0;
      carry_r <= 1'b0;
      err_r   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            carry_r <= bus.carry_in;
            err_r   <= 1'b0;
            state   <= DONE;
            unique case (bus.imm_src)
              IMM_MEM: res <= {{(DATA_W-12){1'b0}}, bus.imm[11:0]};
              IMM_BR:  res <= {{(DATA_W-IMM_W-2){bus.imm[IMM_W-1]}}, bus.imm, 2'b00};
              IMM_RSV: begin
                res   <= '0;
                err_r <= 1'b1;
              end
              default: begin
                res <= {{(DATA_W-8){1'b0}}, bus.imm[7:0]};
                rem <= {bus.imm[11:8], 1'b0};
                if (bus.imm[11:8] != 4'd0) state <= ROT;
              end
            endcase
          end
        end
        ROT: begin
          res <= rot_out;
          rem <= rem - 5'(step);
          if (rem == 5'(step)) begin
            state   <= DONE;
            carry_r <= rot_out[DATA_W-1];
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_imm_unit.sv
// Self-checking bench for ext_imm_unit: vector table with scoreboard, plus
// backpressure, flush and mid-rotation reset sequences. A ROT_STEP=4 copy
// runs in parallel on the same stimulus.
module tb_ext_imm_unit;
  import ext_imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy, busy4;

  always #5 clk = ~clk;

  ext_imm_unit_if #(.DATA_W(32), .IMM_W(24)) b ();
  ext_imm_unit_if #(.DATA_W(32), .IMM_W(24)) b4 ();

  assign b4.in_valid  = b.in_valid;
  assign b4.imm_src   = b.imm_src;
  assign b4.imm       = b.imm;
  assign b4.carry_in  = b.carry_in;
  assign b4.out_ready = b.out_ready;

  ext_imm_unit #(.DATA_W(32), .IMM_W(24), .ROT_STEP(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy), .bus(b.slave));

  ext_imm_unit #(.DATA_W(32), .IMM_W(24), .ROT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy4), .bus(b4.slave));

  typedef struct {
    logic [1:0]  src;
    logic [23:0] imm;
    logic        cin;
    logic [31:0] v;
    logic        c;
    logic        e;
    int          lat;
  } vec_t;

  vec_t tbl [11];
  vec_t sb [$];
  int errors = 0;
  int checks = 0;
  int lat4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Counts edges from the accept edge until out_valid; drops in_valid after the accept edge.
  task automatic wait_valid(output int lat);
    bit got = 0;
    lat  = 0;
    lat4 = 0;
    while (!got && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) b.in_valid = 1'b0;
      if (b4.out_valid && lat4 == 0) lat4 = lat;
      if (b.out_valid) got = 1;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL timeout actual=no out_valid required=out_valid within 64 cycles");
      lat = -1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int exp4;
    vec_t e;
    @(negedge clk);
    chk($sformatf("in_ready_%0d", idx), 64'(b.in_ready), 64'd1);
    b.imm_src  = v.src;
    b.imm      = v.imm;
    b.carry_in = v.cin;
    b.in_valid = 1'b1;
    sb.push_back(v);
    wait_valid(lat);
    if (lat >= 0) begin
      e = sb.pop_front();
      exp4 = (e.src == IMM_DP) ? 1 + rot_cycles(e.imm[11:8], 4) : 1;
      chk($sformatf("latency_%0d", idx), 64'(lat), 64'(e.lat));
      chk($sformatf("ext_imm_%0d", idx), 64'(b.ext_imm), 64'(e.v));
      chk($sformatf("carry_%0d", idx), 64'(b.carry_out), 64'(e.c));
      chk($sformatf("mode_err_%0d", idx), 64'(b.mode_err), 64'(e.e));
      chk($sformatf("ext_imm4_%0d", idx), 64'(b4.ext_imm), 64'(e.v));
      chk($sformatf("latency4_%0d", idx), 64'(lat4), 64'(exp4));
      @(posedge clk);
      #1;
      chk($sformatf("valid_drop_%0d", idx), 64'(b.out_valid), 64'd0);
    end else begin
      void'(sb.pop_front());
    end
  endtask

  int bad;
  int lat_h;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    b.in_valid  = 1'b0;
    b.imm_src   = 2'b00;
    b.imm       = '0;
    b.carry_in  = 1'b0;
    b.out_ready = 1'b1;

    tbl[0]  = '{2'b01, 24'h000078, 1'b1, 32'h00000078, 1'b1, 1'b0, 1};
    tbl[1]  = '{2'b00, 24'h0004FF, 1'b0, 32'hFF000000, 1'b1, 1'b0, 5};
    tbl[2]  = '{2'b10, 24'hFFFFFE, 1'b0, 32'hFFFFFFF8, 1'b0, 1'b0, 1};
    tbl[3]  = '{2'b10, 24'h000001, 1'b1, 32'h00000004, 1'b1, 1'b0, 1};
    tbl[4]  = '{2'b00, 24'h0000AB, 1'b1, 32'h000000AB, 1'b1, 1'b0, 1};
    tbl[5]  = '{2'b11, 24'h123456, 1'b0, 32'h00000000, 1'b0, 1'b1, 1};
    tbl[6]  = '{2'b01, 24'hABCFED, 1'b1, 32'h00000FED, 1'b1, 1'b0, 1};
    tbl[7]  = '{2'b00, 24'h000F01, 1'b1, 32'h00000004, 1'b0, 1'b0, 16};
    tbl[8]  = '{2'b00, 24'h000180, 1'b1, 32'h00000020, 1'b0, 1'b0, 2};
    tbl[9]  = '{2'b00, 24'h000103, 1'b0, 32'hC0000000, 1'b1, 1'b0, 2};
    tbl[10] = '{2'b00, 24'h000A3C, 1'b1, 32'h0003C000, 1'b0, 1'b0, 11};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(b.out_valid), 64'd0);
    chk("rst_ext_imm", 64'(b.ext_imm), 64'd0);
    chk("rst_carry", 64'(b.carry_out), 64'd0);
    chk("rst_mode_err", 64'(b.mode_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(b.in_ready), 64'd1);

    for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

    // Backpressure: hold DONE for 10 cycles while a second request waits.
    @(negedge clk);
    b.out_ready = 1'b0;
    b.imm_src   = IMM_MEM;
    b.imm       = 24'h000123;
    b.carry_in  = 1'b0;
    b.in_valid  = 1'b1;
    wait_valid(lat_h);
    chk("bp_ext_imm", 64'(b.ext_imm), 64'h123);
    b.imm      = 24'h000456;
    b.in_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (b.ext_imm !== 32'h123 || b.out_valid !== 1'b1 || b.in_ready !== 1'b0 ||
          b.carry_out !== 1'b0 || b.mode_err !== 1'b0) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    @(negedge clk);
    b.in_valid  = 1'b0;
    b.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 64'(b.out_valid), 64'd0);
    chk("bp_release_ready", 64'(b.in_ready), 64'd1);
    chk("bp_release_hold", 64'(b.ext_imm), 64'h123);

    // Flush during ROT.
    @(negedge clk);
    b.imm_src  = IMM_DP;
    b.imm      = 24'h000F01;
    b.carry_in = 1'b0;
    b.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(b.in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_valid", 64'(b.out_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (b.out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("flush_no_result", 64'(bad), 64'd0);

    // Flush beats a simultaneous request.
    @(negedge clk);
    flush      = 1'b1;
    b.imm_src  = IMM_MEM;
    b.in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_vs_valid", 64'(busy), 64'd0);
    @(negedge clk);
    flush      = 1'b0;
    b.in_valid = 1'b0;
    run_vec(tbl[1], 101);

    // Asynchronous reset mid-ROT.
    @(negedge clk);
    b.imm_src  = IMM_DP;
    b.imm      = 24'h000F01;
    b.carry_in = 1'b1;
    b.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ext_imm", 64'(b.ext_imm), 64'd0);
    chk("arst_valid", 64'(b.out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_carry", 64'(b.carry_out), 64'd0);
    chk("arst_mode_err", 64'(b.mode_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(tbl[7], 107);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ext_imm_unit.md
Name: ext_imm_unit

Overview:
- Parametrised, handshaked successor to the single-cycle immediate extender in the ProyectoFinal ARM-subset datapath.
- Takes an instruction immediate field plus an ImmSrc mode and returns the DATA_W-bit extended immediate and the shifter carry.
- Data-processing rotated immediates (imm8 ROR 2*rot) are computed iteratively by a small rotator, ROT_STEP bits per cycle.
- Sits between decode and the ALU B-operand mux; multi-cycle control stalls on in_ready/out_valid.

Parameters:
DATA_W, 32, result width; legal values are >= 32.
IMM_W, 24, width of the instruction immediate field; fixed at 24.
ROT_STEP, 2, maximum rotate-right bits applied per ROT cycle; legal values are 1, 2, 4.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort; drops the in-flight transaction
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
imm_src  in  2  mode: 00 DP rotated imm8, 01 MEM imm12 zero-extend, 10 BR imm24 sign-extend <<2, 11 reserved
imm  in  IMM_W  instruction bits [23:0]
carry_in  in  1  current CPSR C flag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
ext_imm  out  DATA_W  extended immediate
carry_out  out  1  shifter carry-out
mode_err  out  1  reserved imm_src seen; qualified by out_valid
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ext_imm=0, carry_out=0, mode_err=0, out_valid=0, busy=0, in_ready=1 once released.
- States: IDLE, ROT, DONE. in_ready = (state==IDLE) && !flush.
- Accept: in_valid && in_ready at edge k. At accept, latch imm_src, imm and carry_in.
- Mode 01: result = zero-extend imm[11:0]. Next state DONE.
- Mode 10: result = sign-extend {imm[23:0],2'b00} to DATA_W. Next state DONE.
- Mode 11: result = 0, mode_err=1. Next state DONE.
- Mode 00:
  - Load result = zero-extend imm[7:0]; rem = 2*imm[11:8] (0..30).
  - If rem==0, go to DONE.
  - Otherwise go to ROT. Each ROT cycle: step = min(ROT_STEP, rem); result ROR step over DATA_W bits; rem -= step; move to DONE when rem reaches 0.
- Latency: N = ceil(2*rot/ROT_STEP), with N=0 for non-DP modes or rot=0. out_valid is first high in cycle k+1+N.
- carry_out:
  - DP with rot!=0: ext_imm[DATA_W-1].
  - All other cases: latched carry_in.
- DONE:
  - out_valid=1.
  - ext_imm, carry_out and mode_err stay stable while out_ready=0.
  - On out_ready, go to IDLE. out_valid drops the following cycle.
  - No accept while in DONE. Sustained throughput is one transaction per 2+N cycles.
- flush=1 at any edge: state goes to IDLE, out_valid=0 and rem=0; ext_imm holds its last value.
  - flush beats a simultaneous in_valid (nothing is accepted).
  - flush beats a simultaneous out_ready (the transaction is discarded).
- Reset asserted mid-ROT or mid-DONE: immediate return to reset values; no partial result is ever presented.
- Inputs other than in_valid, flush and out_ready are don't-care when no accept occurs.

Decomposition:
- Package ext_imm_pkg:
  - imm_src encodings IMM_DP=2'b00, IMM_MEM=2'b01, IMM_BR=2'b10, IMM_RSV=2'b11.
  - State enum IDLE/ROT/DONE.
  - Function rot_cycles(rot, step) for bench latency prediction.
- Sub-module ror_step: combinational rotate right of a DATA_W word by 0..ROT_STEP bits. Instantiated once.
- FSM, counters and registers live in the top module.

Test Plan:
- Latency, MEM mode: imm_src=01, imm=24'h000078 -> ext_imm=32'h00000078 with out_valid at k+1 (latency 1); carry_out=carry_in.
- Rotated DP: imm_src=00, imm=24'h0004FF, carry_in=0, ROT_STEP=2 -> four ROT cycles, out_valid at k+5, ext_imm=32'hFF000000, carry_out=1. Repeat with ROT_STEP=4 -> out_valid at k+3.
- Branch and DP rot=0:
  - imm_src=10, imm=24'hFFFFFE -> ext_imm=32'hFFFFFFF8.
  - imm_src=10, imm=24'h000001 -> ext_imm=32'h00000004.
  - imm_src=00, imm=24'h0000AB, carry_in=1 -> ext_imm=32'h000000AB, carry_out=1, latency 1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0; release -> IDLE, in_ready=1 the next cycle.
- Reserved mode: imm_src=11 -> ext_imm=0, mode_err=1, out_valid=1.
- Abort and reset:
  - flush during ROT (imm=24'h000F01) -> IDLE next cycle, no out_valid.
  - rst_n low mid-ROT -> all outputs 0 asynchronously.
  - A new request after either completes correctly.
